// File: rtl/pampy_loader_if.sv
// Byte-stream and instruction-memory write bundle for pampy_loader.
// master: loader side; slave: stream source / memory side.
interface pampy_loader_if #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 12,
  parameter int unsigned INSTRUCTION_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]        BYTE_IN;
  logic                         BYTE_VALID;
  logic                         BYTE_READY;
  logic                         MEM_WR_EN;
  logic [ADDR_WIDTH-1:0]        MEM_WR_ADDR;
  logic [INSTRUCTION_WIDTH-1:0] MEM_WR_DATA;

  modport master (
    input  BYTE_IN, BYTE_VALID,
    output BYTE_READY, MEM_WR_EN, MEM_WR_ADDR, MEM_WR_DATA
  );

  modport slave (
    output BYTE_IN, BYTE_VALID,
    input  BYTE_READY, MEM_WR_EN, MEM_WR_ADDR, MEM_WR_DATA
  );
endinterface

// File: rtl/pampy_loader.sv
// Program loader for the pamPy core: byte stream -> {opcode, argument} words -> instr memory.
// Optional trailing XOR checksum byte enabled by `PAMPY_LOADER_CHECKSUM_EN.
module pampy_loader #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 12,
  parameter int unsigned INSTRUCTION_WIDTH = 16
) (
  input  logic                  general_clk,
  input  logic                  general_reset,
  input  logic                  LOAD_START,
  input  logic [ADDR_WIDTH-1:0] LOAD_LEN,
  pampy_loader_if.master        bus,
  output logic                  CORE_RESET_N,
  input  logic                  CORE_FINISH,
  output logic                  LOAD_BUSY,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERR,
  output logic                  CORE_HALTED
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RX_HI   = 3'd1;
  localparam logic [2:0] RX_LO   = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] RELEASE = 3'd5;
  localparam logic [2:0] RUN     = 3'd6;
`ifdef PAMPY_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] ERROR   = 3'd7;
  localparam logic [2:0] LAST_NEXT = CHECK;
`else
  localparam logic [2:0] LAST_NEXT = RELEASE;
`endif

  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        len_q, cnt_q, cnt_inc;
  logic [INSTRUCTION_WIDTH-1:0] word_q;
  logic                         halted_q;
  logic                         ready, xfer, start_ok;
`ifdef PAMPY_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]        xor_q;
  logic                         err_q;
  logic                         sum_ok;
  assign sum_ok   = (bus.BYTE_IN == xor_q);
  assign ready    = (state_q == RX_HI) || (state_q == RX_LO) || (state_q == CHECK);
  assign start_ok = LOAD_START &&
                    ((state_q == IDLE) || (state_q == RUN) || (state_q == ERROR));
  assign LOAD_BUSY = ready || (state_q == WRITE);
  assign LOAD_ERR  = err_q;
`else
  assign ready     = (state_q == RX_HI) || (state_q == RX_LO);
  assign start_ok  = LOAD_START && ((state_q == IDLE) || (state_q == RUN));
  assign LOAD_BUSY = ready || (state_q == WRITE);
  assign LOAD_ERR  = 1'b0;
`endif

  assign xfer    = bus.BYTE_VALID && ready;
  assign cnt_inc = cnt_q + ADDR_WIDTH'(1);

  // All outputs decode the registered state, so nothing here follows BYTE_VALID.
  assign bus.BYTE_READY  = ready;
  assign bus.MEM_WR_EN   = (state_q == WRITE);
  assign bus.MEM_WR_ADDR = cnt_q;
  assign bus.MEM_WR_DATA = word_q;
  assign CORE_RESET_N    = (state_q == RUN);
  assign LOAD_DONE       = (state_q == RELEASE);
  assign CORE_HALTED     = halted_q;

  always_comb begin
    state_d = state_q;
    if (start_ok) begin
      state_d = (LOAD_LEN == '0) ? LAST_NEXT : RX_HI;
    end else begin
      case (state_q)
        RX_HI:   if (xfer) state_d = RX_LO;
        RX_LO:   if (xfer) state_d = WRITE;
        WRITE:   state_d = (cnt_inc == len_q) ? LAST_NEXT : RX_HI;
`ifdef PAMPY_LOADER_CHECKSUM_EN
        CHECK:   if (xfer) state_d = sum_ok ? RELEASE : ERROR;
`endif
        RELEASE: state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge general_clk or negedge general_reset) begin
    if (!general_reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      halted_q <= 1'b0;
`ifdef PAMPY_LOADER_CHECKSUM_EN
      xor_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q    <= LOAD_LEN;
        cnt_q    <= '0;
        halted_q <= 1'b0;
`ifdef PAMPY_LOADER_CHECKSUM_EN
        xor_q    <= '0;
        err_q    <= 1'b0;
`endif
      end else begin
        // LOAD_START takes priority over a same-cycle CORE_FINISH.
        if ((state_q == RUN) && CORE_FINISH) halted_q <= 1'b1;
        if (xfer && (state_q == RX_HI)) word_q[INSTRUCTION_WIDTH-1:DATA_WIDTH] <= bus.BYTE_IN;
        if (xfer && (state_q == RX_LO)) word_q[DATA_WIDTH-1:0] <= bus.BYTE_IN;
        if (state_q == WRITE) cnt_q <= cnt_inc;
`ifdef PAMPY_LOADER_CHECKSUM_EN
        if (xfer) xor_q <= xor_q ^ bus.BYTE_IN;
        if (xfer && (state_q == CHECK) && !sum_ok) err_q <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pampy_loader.sv
// Directed self-checking bench for pampy_loader (checksum steps follow the same macro).
module tb_pampy_loader;

  logic        general_clk;
  logic        general_reset;
  logic        LOAD_START;
  logic [11:0] LOAD_LEN;
  logic        CORE_RESET_N;
  logic        CORE_FINISH;
  logic        LOAD_BUSY;
  logic        LOAD_DONE;
  logic        LOAD_ERR;
  logic        CORE_HALTED;

  pampy_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16)) bus_if ();

  pampy_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16)) dut (
    .general_clk  (general_clk),
    .general_reset(general_reset),
    .LOAD_START   (LOAD_START),
    .LOAD_LEN     (LOAD_LEN),
    .bus          (bus_if),
    .CORE_RESET_N (CORE_RESET_N),
    .CORE_FINISH  (CORE_FINISH),
    .LOAD_BUSY    (LOAD_BUSY),
    .LOAD_DONE    (LOAD_DONE),
    .LOAD_ERR     (LOAD_ERR),
    .CORE_HALTED  (CORE_HALTED)
  );

  initial general_clk = 1'b0;
  always #5 general_clk = ~general_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Write/pulse monitor sampled mid-cycle.
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          bad_cnt  = 0;
  logic [15:0] wr_data_log [0:31];
  logic [11:0] wr_addr_log [0:31];

  always @(negedge general_clk) begin
    if (bus_if.MEM_WR_EN) begin
      if (wr_cnt < 32) begin
        wr_data_log[wr_cnt] <= bus_if.MEM_WR_DATA;
        wr_addr_log[wr_cnt] <= bus_if.MEM_WR_ADDR;
      end
      wr_cnt <= wr_cnt + 1;
      if (bus_if.BYTE_READY || !LOAD_BUSY || CORE_RESET_N) bad_cnt <= bad_cnt + 1;
    end
    if (LOAD_DONE) begin
      done_cnt <= done_cnt + 1;
      if (CORE_RESET_N || LOAD_BUSY) bad_cnt <= bad_cnt + 1;
    end
    if (LOAD_BUSY && CORE_RESET_N) bad_cnt <= bad_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge general_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited;
    waited = 0;
    if (stall) begin
      bus_if.BYTE_VALID = 1'b0;
      tick();
    end
    bus_if.BYTE_IN    = b;
    bus_if.BYTE_VALID = 1'b1;
    while (!bus_if.BYTE_READY && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chki("byte_ready_timeout", waited, 0);
    tick();
    bus_if.BYTE_VALID = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ready"}, bus_if.BYTE_READY, 1'b0);
    chk1({tag, "_wr_en"}, bus_if.MEM_WR_EN, 1'b0);
    chk16({tag, "_addr"}, {4'h0, bus_if.MEM_WR_ADDR}, 16'h0000);
    chk16({tag, "_data"}, bus_if.MEM_WR_DATA, 16'h0000);
    chk1({tag, "_core_rst_n"}, CORE_RESET_N, 1'b0);
    chk1({tag, "_busy"}, LOAD_BUSY, 1'b0);
    chk1({tag, "_done"}, LOAD_DONE, 1'b0);
    chk1({tag, "_err"}, LOAD_ERR, 1'b0);
    chk1({tag, "_halted"}, CORE_HALTED, 1'b0);
  endtask

  initial begin
    int base_w;
    int base_d;
    general_reset     = 1'b0;
    LOAD_START        = 1'b0;
    LOAD_LEN          = '0;
    CORE_FINISH       = 1'b0;
    bus_if.BYTE_IN    = '0;
    bus_if.BYTE_VALID = 1'b0;

    #12;
    chk_reset_outputs("reset");
    tick();
    general_reset = 1'b1;
    tick();
    chk1("idle_busy", LOAD_BUSY, 1'b0);

    // Basic two-word load; LOAD_LEN is changed after acceptance to prove it was latched.
    base_w = wr_cnt;
    base_d = done_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd2;
    tick();
    LOAD_START = 1'b0;
    LOAD_LEN   = 12'd9;
    chk1("t1_busy", LOAD_BUSY, 1'b1);
    chk1("t1_ready", bus_if.BYTE_READY, 1'b1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk1("t1_w0_en", bus_if.MEM_WR_EN, 1'b1);
    chk16("t1_w0_addr", {4'h0, bus_if.MEM_WR_ADDR}, 16'h0000);
    chk16("t1_w0_data", bus_if.MEM_WR_DATA, 16'h1234);
    chk1("t1_w0_ready", bus_if.BYTE_READY, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    chk16("t1_w1_addr", {4'h0, bus_if.MEM_WR_ADDR}, 16'h0001);
    chk16("t1_w1_data", bus_if.MEM_WR_DATA, 16'h5678);
`ifdef PAMPY_LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b0);
`else
    tick();
`endif
    chk1("t1_done", LOAD_DONE, 1'b1);
    chk1("t1_release_core_rst", CORE_RESET_N, 1'b0);
    tick();
    chk1("t1_done_drop", LOAD_DONE, 1'b0);
    chk1("t1_run_core_rst", CORE_RESET_N, 1'b1);
    chki("t1_writes", wr_cnt - base_w, 2);
    chk16("t1_log0", wr_data_log[base_w], 16'h1234);
    chk16("t1_log1", wr_data_log[base_w + 1], 16'h5678);
    chki("t1_done_pulses", done_cnt - base_d, 1);

    // Same load from RUN with stalls on BYTE_VALID.
    base_w = wr_cnt;
    base_d = done_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd2;
    tick();
    LOAD_START = 1'b0;
    chk1("t2_restart_core_rst", CORE_RESET_N, 1'b0);
    send_byte(8'h12, 1'b1);
    chk1("t2_stall_no_wr", bus_if.MEM_WR_EN, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
`ifdef PAMPY_LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b1);
`else
    tick();
`endif
    chk1("t2_done", LOAD_DONE, 1'b1);
    tick();
    chk1("t2_run_core_rst", CORE_RESET_N, 1'b1);
    chki("t2_writes", wr_cnt - base_w, 2);
    chk16("t2_log0", wr_data_log[base_w], 16'h1234);
    chk16("t2_addr1", {4'h0, wr_addr_log[base_w + 1]}, 16'h0001);
    chk16("t2_log1", wr_data_log[base_w + 1], 16'h5678);
    chki("t2_done_pulses", done_cnt - base_d, 1);

    // Core finish in RUN, then an empty load clears it.
    CORE_FINISH = 1'b1;
    tick();
    CORE_FINISH = 1'b0;
    chk1("t3_halted", CORE_HALTED, 1'b1);
    chk1("t3_core_rst", CORE_RESET_N, 1'b1);
    tick();
    chk1("t3_halted_sticky", CORE_HALTED, 1'b1);
    base_w = wr_cnt;
    base_d = done_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd0;
    tick();
    LOAD_START = 1'b0;
    chk1("t3_halted_clr", CORE_HALTED, 1'b0);
    chk1("t3_core_rst_drop", CORE_RESET_N, 1'b0);
`ifdef PAMPY_LOADER_CHECKSUM_EN
    chk1("t3_check_ready", bus_if.BYTE_READY, 1'b1);
    send_byte(8'h00, 1'b0);
`endif
    chk1("t3_done", LOAD_DONE, 1'b1);
    tick();
    chk1("t3_run_core_rst", CORE_RESET_N, 1'b1);
    chki("t3_no_writes", wr_cnt - base_w, 0);
    chki("t3_done_pulses", done_cnt - base_d, 1);

    // LOAD_START and CORE_FINISH together: start wins.
    LOAD_START  = 1'b1;
    LOAD_LEN    = 12'd0;
    CORE_FINISH = 1'b1;
    tick();
    LOAD_START  = 1'b0;
    CORE_FINISH = 1'b0;
    chk1("t4_halted", CORE_HALTED, 1'b0);
    chk1("t4_core_rst", CORE_RESET_N, 1'b0);
`ifdef PAMPY_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    chk1("t4_done", LOAD_DONE, 1'b1);
    tick();
    chk1("t4_run_core_rst", CORE_RESET_N, 1'b1);

`ifdef PAMPY_LOADER_CHECKSUM_EN
    // Bad checksum: correct value would be 0x26.
    base_d = done_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd1;
    tick();
    LOAD_START = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk1("t5_err", LOAD_ERR, 1'b1);
    chk1("t5_core_rst", CORE_RESET_N, 1'b0);
    chk1("t5_busy", LOAD_BUSY, 1'b0);
    tick();
    tick();
    chk1("t5_err_sticky", LOAD_ERR, 1'b1);
    chk1("t5_core_rst_held", CORE_RESET_N, 1'b0);
    chki("t5_no_done", done_cnt - base_d, 0);
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd0;
    tick();
    LOAD_START = 1'b0;
    chk1("t5_err_clr", LOAD_ERR, 1'b0);
    send_byte(8'h00, 1'b0);
    chk1("t5_done", LOAD_DONE, 1'b1);
    tick();
    chk1("t5_run_core_rst", CORE_RESET_N, 1'b1);
`endif

    // Reset after the third byte of a four-word load.
    base_w = wr_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd4;
    tick();
    LOAD_START = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    general_reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    general_reset = 1'b1;
    tick();
    chki("t6_partial_writes", wr_cnt - base_w, 1);
    chk1("t6_idle_busy", LOAD_BUSY, 1'b0);
    base_w = wr_cnt;
    LOAD_START = 1'b1;
    LOAD_LEN   = 12'd1;
    tick();
    LOAD_START = 1'b0;
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    chk16("t6_addr", {4'h0, bus_if.MEM_WR_ADDR}, 16'h0000);
    chk16("t6_data", bus_if.MEM_WR_DATA, 16'hABCD);
`ifdef PAMPY_LOADER_CHECKSUM_EN
    send_byte(8'h66, 1'b0);
`else
    tick();
`endif
    chk1("t6_done", LOAD_DONE, 1'b1);
    tick();
    chk1("t6_run_core_rst", CORE_RESET_N, 1'b1);
    chki("t6_writes", wr_cnt - base_w, 1);
    chki("protocol_violations", bad_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pampy_loader.md
# pampy_loader

Program loader sitting directly upstream of the pamPy core. It accepts a byte stream over a valid/ready handshake, assembles {opcode, argument} instruction words, and writes them sequentially into the core's instruction memory. The core is held in reset for the whole load and released only after a complete, successful load. The block also reports when the core signals finish.

## Interface
- DATA_WIDTH, 8: byte width; also the opcode and argument field width
- ADDR_WIDTH, 12: instruction memory address width
- INSTRUCTION_WIDTH, 16: memory word width; must equal 2*DATA_WIDTH

Ports:
- general_clk  in  1  sole clock; all state changes on the rising edge
- general_reset  in  1  asynchronous, active-low reset
- LOAD_START  in  1  single-cycle request to begin a load session
- LOAD_LEN  in  ADDR_WIDTH  instruction count; sampled only in the cycle LOAD_START is accepted
- BYTE_IN  in  DATA_WIDTH  stream byte
- BYTE_VALID  in  1  BYTE_IN is valid
- BYTE_READY  out  1  loader can accept a byte
- MEM_WR_EN  out  1  instruction memory write strobe
- MEM_WR_ADDR  out  ADDR_WIDTH  write address
- MEM_WR_DATA  out  INSTRUCTION_WIDTH  {opcode, argument}
- CORE_RESET_N  out  1  active-low reset to the core
- CORE_FINISH  in  1  core finish flag
- LOAD_BUSY  out  1  load session in progress
- LOAD_DONE  out  1  one-cycle pulse on successful completion
- LOAD_ERR  out  1  sticky checksum failure
- CORE_HALTED  out  1  sticky; core reported finish

## Operation
- States: IDLE, RX_HI, RX_LO, WRITE, CHECK, RELEASE, RUN, ERROR.
- Reset values: state IDLE. BYTE_READY, MEM_WR_EN, LOAD_BUSY, LOAD_DONE, LOAD_ERR and CORE_HALTED are 0. MEM_WR_ADDR and MEM_WR_DATA are 0. CORE_RESET_N is 0.
- IDLE, RUN and ERROR accept LOAD_START. On acceptance:
  - latch LOAD_LEN, clear the address counter, XOR accumulator, LOAD_ERR and CORE_HALTED
  - drive CORE_RESET_N low
  - go to RX_HI, or go directly to CHECK/RELEASE if LOAD_LEN=0
- LOAD_START is ignored in every other state.
- RX_HI: BYTE_READY=1. A transfer (BYTE_VALID & BYTE_READY) latches the opcode into [15:8] and moves to RX_LO.
- RX_LO: BYTE_READY=1. A transfer latches the argument into [7:0] and moves to WRITE.
- WRITE: MEM_WR_EN=1 for exactly one cycle, MEM_WR_ADDR = counter. Then the counter increments.
  - if counter+1 == LOAD_LEN, go to CHECK (macro defined) or RELEASE
  - otherwise go to RX_HI
- The counter never wraps. The maximum load is 2^ADDR_WIDTH-1 words.
- Every accepted byte is XORed into an 8-bit accumulator.
- RELEASE: LOAD_DONE=1 for one cycle. Next state RUN.
- RUN: CORE_RESET_N=1. CORE_FINISH=1 sets CORE_HALTED; the core stays out of reset.
- LOAD_BUSY=1 in RX_HI, RX_LO, WRITE and CHECK.
- A reset mid-load discards the partial image; no further writes occur.

## Timing
- BYTE_READY is a registered state decode. It never depends combinationally on BYTE_VALID.
- Minimum 3 cycles per instruction (hi byte, lo byte, write). BYTE_VALID stalls extend the matching RX state indefinitely.
- MEM_WR_ADDR and MEM_WR_DATA are stable throughout the MEM_WR_EN cycle.
- Release sequence: last WRITE cycle, then RELEASE cycle (LOAD_DONE=1, CORE_RESET_N still 0). CORE_RESET_N rises on the edge that ends RELEASE.
- LOAD_START in RUN drops CORE_RESET_N on the next edge, together with the move to RX_HI.
- If CORE_FINISH and LOAD_START arrive in the same RUN cycle, LOAD_START wins and CORE_HALTED stays 0.

## Configuration
- Macro `PAMPY_LOADER_CHECKSUM_EN`.
- Defined:
  - after the last word, CHECK asserts BYTE_READY and accepts one checksum byte
  - the checksum byte is correct if it equals the XOR of all preceding bytes in the session (0x00 when LOAD_LEN=0)
  - match: go to RELEASE
  - mismatch: set LOAD_ERR and go to ERROR; the core stays in reset
- Undefined: CHECK and ERROR do not exist, and LOAD_ERR is tied 0.

## Test plan
- Reset, then LOAD_START with LOAD_LEN=2 and bytes 0x12,0x34,0x56,0x78 (+0x08 checksum if enabled) → writes 0x1234@0 and 0x5678@1, one LOAD_DONE pulse, CORE_RESET_N high one cycle after RELEASE.
- Same load with BYTE_VALID toggling every other cycle → identical writes; no MEM_WR_EN outside WRITE; CORE_RESET_N low until completion.
- LOAD_LEN=0 → no MEM_WR_EN. RELEASE immediately (disabled), or after a 0x00 checksum (enabled).
- Checksum enabled, wrong checksum 0xFF → LOAD_ERR=1, no LOAD_DONE, CORE_RESET_N stays 0. A new LOAD_START clears LOAD_ERR.
- In RUN, CORE_FINISH=1 → CORE_HALTED=1, CORE_RESET_N stays 1. A later LOAD_START clears it and drops CORE_RESET_N on the next edge.
- general_reset low after the 3rd byte of a 4-word load → all outputs return to reset values immediately. A fresh load then starts writing at address 0.
